// File: rtl/uiae_ctrl.sv
// Frame-mean auto-exposure controller: measures mean luma per frame and
// nudges the sensor exposure code toward a target with a dead band.
module uiae_ctrl #(
  parameter logic [7:0] TARGET    = 8'd110,
  parameter logic [7:0] HYST      = 8'd10,
  parameter logic [7:0] STEP      = 8'd2,
  parameter logic [7:0] E_MIN     = 8'd8,
  parameter logic [7:0] E_MAX     = 8'd240,
  parameter logic [7:0] E_INIT    = 8'd8,
  parameter int         PIX_SHIFT = 23,
  parameter int         SKIP      = 2
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_cfg_done,
  input  logic       I_vs,
  input  logic       I_de,
  input  logic [7:0] I_y,
  input  logic       I_ae_cfg_done,
  output logic       O_ae_req,
  output logic [7:0] O_ae_data,
  output logic [7:0] O_mean,
  output logic       O_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCUM   = 3'd1;
  localparam logic [2:0] S_CALC    = 3'd2;
  localparam logic [2:0] S_DECIDE  = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
  localparam logic [2:0] S_SETTLE  = 3'd6;

  localparam logic [7:0] SKIP_V = 8'(SKIP);

  logic [2:0]  state;
  logic        vs_q;
  logic        vs_rise;
  logic [31:0] sum;
  logic [23:0] cnt;
  logic [7:0]  skip_cnt;

  logic [31:0] mean_full;
  logic [7:0]  mean_sat;
  logic [8:0]  ae9;
  logic [8:0]  up9;
  logic [8:0]  dn9;
  logic [8:0]  mean9;
  logic [8:0]  hi_th;
  logic [8:0]  lo_lim;
  logic [7:0]  next_ae;

  assign vs_rise   = I_vs & ~vs_q;
  assign mean_full = sum >> PIX_SHIFT;
  assign mean_sat  = (|mean_full[31:8]) ? 8'hFF
                                        : mean_full[7:0];
  assign O_busy    = (state != S_IDLE) &&
                     (state != S_ACCUM);

  // 9-bit math so neither the thresholds nor
  // the stepped code can wrap around
  assign ae9    = {1'b0, O_ae_data};
  assign up9    = ae9 + {1'b0, STEP};
  assign dn9    = ae9 - {1'b0, STEP};
  assign mean9  = {1'b0, O_mean};
  assign hi_th  = {1'b0, TARGET} + {1'b0, HYST};
  assign lo_lim = {1'b0, E_MIN} + {1'b0, STEP};

  always_comb begin
    next_ae = O_ae_data;
    if (mean9 > hi_th) begin
      next_ae = (up9 > {1'b0, E_MAX}) ? E_MAX
                                      : up9[7:0];
    end else if (mean9 + {1'b0, HYST} <
                 {1'b0, TARGET}) begin
      next_ae = (ae9 < lo_lim) ? E_MIN
                               : dn9[7:0];
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state     <= S_IDLE;
      vs_q      <= 1'b0;
      sum       <= '0;
      cnt       <= '0;
      skip_cnt  <= '0;
      O_ae_req  <= 1'b0;
      O_ae_data <= E_INIT;
      O_mean    <= '0;
    end else begin
      vs_q     <= I_vs;
      O_ae_req <= 1'b0;
      if (!I_cfg_done) begin
        state    <= S_IDLE;
        sum      <= '0;
        cnt      <= '0;
        skip_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (vs_rise) begin
              state <= S_ACCUM;
              sum   <= '0;
              cnt   <= '0;
            end
          end
          S_ACCUM: begin
            if (vs_rise) begin
              state <= S_CALC;
            end else if (I_de) begin
              sum <= sum + {24'd0, I_y};
              cnt <= cnt + 24'd1;
            end
          end
          S_CALC: begin
            if (cnt == 24'd0) begin
              state <= S_IDLE;
            end else begin
              O_mean <= mean_sat;
              state  <= S_DECIDE;
            end
          end
          S_DECIDE: begin
            if (next_ae != O_ae_data) begin
              O_ae_data <= next_ae;
              O_ae_req  <= 1'b1;
              state     <= S_WAIT_LO;
            end else begin
              state <= S_ACCUM;
              sum   <= '0;
              cnt   <= '0;
            end
          end
          S_WAIT_LO: begin
            if (!I_ae_cfg_done)
              state <= S_WAIT_HI;
          end
          S_WAIT_HI: begin
            if (I_ae_cfg_done) begin
              skip_cnt <= SKIP_V;
              state    <= (SKIP_V == 8'd0) ? S_IDLE
                                           : S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (skip_cnt == 8'd0)
              state <= S_IDLE;
            else if (vs_rise)
              skip_cnt <= skip_cnt - 8'd1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uiae_ctrl.sv
// Directed bench for uiae_ctrl: 16-pixel frames, main instance
// PIX_SHIFT=4/SKIP=1, second instance PIX_SHIFT=3/SKIP=0/E_INIT=9.
module tb_uiae_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg, cfg3;
  logic       vs, de, ae_done, ae_done3;
  logic [7:0] y;
  logic       req, busy, req3, busy3;
  logic [7:0] ae, mean, ae3, mean3;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  logic mon_en = 1'b0;
  logic busy_drop = 1'b0;

  always #5 clk = ~clk;

  uiae_ctrl #(
    .PIX_SHIFT(4),
    .SKIP(1)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .I_cfg_done(cfg),
    .I_vs(vs),
    .I_de(de),
    .I_y(y),
    .I_ae_cfg_done(ae_done),
    .O_ae_req(req),
    .O_ae_data(ae),
    .O_mean(mean),
    .O_busy(busy)
  );

  uiae_ctrl #(
    .E_INIT(8'd9),
    .PIX_SHIFT(3),
    .SKIP(0)
  ) dut3 (
    .I_clk(clk),
    .I_rst(rst),
    .I_cfg_done(cfg3),
    .I_vs(vs),
    .I_de(de),
    .I_y(y),
    .I_ae_cfg_done(ae_done3),
    .O_ae_req(req3),
    .O_ae_data(ae3),
    .O_mean(mean3),
    .O_busy(busy3)
  );

  always @(negedge clk)
    if (mon_en && !busy) busy_drop = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_edge();
    vs = 1'b1;
    tick();
    vs = 1'b0;
  endtask

  task automatic pixels(input logic [7:0] v,
                        input int n);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      y  = v;
      tick();
    end
    de = 1'b0;
    y  = 8'd0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg = 1'b1; cfg3 = 1'b0;
    vs = 1'b0; de = 1'b0; y = 8'd0;
    ae_done = 1'b1; ae_done3 = 1'b1;
    repeat (3) tick();
    chk("rst_ae", ae, 8);
    chk("rst_mean", mean, 0);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ae3", ae3, 9);
    rst = 1'b0;
    tick();

    // bright frame
    vs_edge();
    pixels(8'd200, 16);
    vs_edge();
    tick();
    chk("bright_mean", mean, 200);
    chk("bright_req_early", req, 0);
    tick();
    chk("bright_req", req, 1);
    chk("bright_ae", ae, 10);
    chk("bright_busy", busy, 1);
    mon_en = 1'b1;
    tick();
    chk("bright_req_1cyc", req, 0);

    // handshake then one skipped frame
    ae_done = 1'b0;
    repeat (500) tick();
    chk("hs_no_req", req, 0);
    ae_done = 1'b1;
    tick();
    vs_edge();
    mon_en = 1'b0;
    chk("hs_busy_hold", busy_drop, 0);
    tick();
    chk("settle_idle", busy, 0);
    pixels(8'd20, 16);

    // measured in-band frame
    vs_edge();
    pixels(8'd115, 16);
    vs_edge();
    tick();
    chk("inband_mean", mean, 115);
    tick();
    chk("inband_req", req, 0);
    chk("inband_accum", busy, 0);
    chk("inband_ae_hold", ae, 10);

    // empty frame
    vs_edge();
    tick();
    chk("empty_mean", mean, 115);
    chk("empty_idle", busy, 0);
    tick();
    chk("empty_req", req, 0);

    // gated by cfg_done low
    cfg = 1'b0;
    vs_edge();
    pixels(8'd200, 16);
    vs_edge();
    tick();
    chk("gate_mean", mean, 115);
    tick();
    chk("gate_req", req, 0);
    chk("gate_busy", busy, 0);

    // cfg_done drop mid-frame discards sum
    cfg = 1'b1;
    vs_edge();
    pixels(8'd200, 8);
    cfg = 1'b0;
    tick();
    cfg = 1'b1;
    tick();
    vs_edge();
    pixels(8'd100, 16);
    vs_edge();
    tick();
    chk("cfgdrop_mean", mean, 100);
    tick();
    chk("cfgdrop_req", req, 0);
    chk("cfgdrop_accum", busy, 0);

    // async reset mid-ACCUM
    pixels(8'd200, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ae", ae, 8);
    chk("arst_mean", mean, 0);
    chk("arst_req", req, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // no accumulation before a fresh vs_rise
    pixels(8'd200, 16);
    vs_edge();
    pixels(8'd115, 16);
    vs_edge();
    tick();
    chk("post_rst_mean", mean, 115);
    tick();
    chk("post_rst_req", req, 0);

    // second instance: dark frames at limit
    cfg = 1'b0;
    cfg3 = 1'b1;
    tick();
    vs_edge();
    pixels(8'd20, 16);
    vs_edge();
    tick();
    chk("dark_mean3", mean3, 40);
    tick();
    chk("dark_req3", req3, 1);
    chk("dark_ae3", ae3, 8);
    tick();
    chk("dark_req3_1cyc", req3, 0);
    ae_done3 = 1'b0;
    tick();
    ae_done3 = 1'b1;
    tick();
    chk("skip0_idle3", busy3, 0);
    vs_edge();
    pixels(8'd20, 16);
    vs_edge();
    tick();
    tick();
    chk("dark2_req3", req3, 0);
    chk("dark2_ae3", ae3, 8);
    chk("dark2_accum3", busy3, 0);

    // saturation
    pixels(8'd255, 16);
    vs_edge();
    tick();
    chk("sat_mean3", mean3, 255);
    chk("main_quiet_req", req, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
